// File: rtl/pipes_pkg.sv
// Shared pipeline-control types: FSM state encoding and the PC redirect record.
package pipes;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        REDIR = 2'd1,
        IWAIT = 2'd2,
        DWAIT = 2'd3
    } ctrl_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } redirect_t;

    localparam logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the execute-stage load and the decode sources.
module load_use_detect (
    input  logic [4:0] dec_rs,
    input  logic [4:0] dec_rt,
    input  logic       dec_uses_rt,
    input  logic       ex_load,
    input  logic [4:0] ex_wreg,
    output logic       hazard
);

    // Register 0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = ex_load && (ex_wreg != 5'd0) &&
                    ((ex_wreg == dec_rs) || (dec_uses_rt && (ex_wreg == dec_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush/redirect controller with a saturating stall-cycle counter.
module pipeline_ctrl
    import pipes::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic        dec_uses_rt,
    input  logic        ex_load,
    input  logic [4:0]  ex_wreg,
    input  logic        branch_judge,
    input  logic        jump_judge,
    input  logic [31:0] branch_address,
    input  logic [31:0] jump_address,
    input  logic        i_busy,
    input  logic        d_busy,
    output logic        stall_f,
    output logic        stall_d,
    output logic        flush_d,
    output logic        flush_e,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [31:0] stall_count
);

    ctrl_state_t state_q, state_d;
    logic [31:0] target_q, target_d;
    logic        pending_q, pending_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        hazard;
    logic        stall_c, flush_d_c, flush_e_c;
    redirect_t   redirect;

    load_use_detect u_load_use_detect (
        .dec_rs      (dec_rs),
        .dec_rt      (dec_rt),
        .dec_uses_rt (dec_uses_rt),
        .ex_load     (ex_load),
        .ex_wreg     (ex_wreg),
        .hazard      (hazard)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        pending_d = pending_q;
        stall_c   = 1'b0;
        flush_d_c = 1'b0;
        flush_e_c = 1'b0;
        if (d_busy) begin
            stall_c = 1'b1;
            state_d = DWAIT;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hazard) begin
                        stall_c   = 1'b1;
                        flush_e_c = 1'b1;
                    end else if (branch_judge || jump_judge) begin
                        target_d  = branch_judge ? branch_address : jump_address;
                        pending_d = 1'b1;
                        state_d   = i_busy ? IWAIT : REDIR;
                    end else if (i_busy) begin
                        stall_c = 1'b1;
                    end
                end
                IWAIT: begin
                    stall_c = 1'b1;
                    if (!i_busy) state_d = REDIR;
                end
                REDIR: begin
                    flush_d_c = 1'b1;
                    pending_d = 1'b0;
                    state_d   = RUN;
                end
                DWAIT: state_d = pending_q ? REDIR : RUN;
                default: state_d = RUN;
            endcase
        end
    end

    // Reset masks the combinational outputs too, so they drop without waiting for a clock.
    assign stall_f = reset && stall_c;
    assign stall_d = reset && stall_c;
    assign flush_d = reset && flush_d_c;
    assign flush_e = reset && flush_e_c;

    assign stall_cnt_d = (stall_f && (stall_cnt_q != STALL_CNT_MAX)) ? stall_cnt_q + 32'd1
                                                                      : stall_cnt_q;

    // NOTE: sequential state uses non-blocking assignments and an asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            target_q    <= '0;
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Redirect depends only on flops, so no path exists from branch_judge to redirect_valid.
    assign redirect.valid = (state_q == REDIR);
    assign redirect.pc    = redirect.valid ? target_q : 32'd0;

    assign redirect_valid = redirect.valid;
    assign redirect_pc    = redirect.pc;
    assign stall_count    = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl with hand-computed expectations.
module tb_pipeline_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  dec_rs, dec_rt, ex_wreg;
    logic        dec_uses_rt, ex_load;
    logic        branch_judge, jump_judge;
    logic [31:0] branch_address, jump_address;
    logic        i_busy, d_busy;
    logic        stall_f, stall_d, flush_d, flush_e, redirect_valid;
    logic [31:0] redirect_pc, stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Output vector order: {stall_f, stall_d, flush_d, flush_e, redirect_valid}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_STALL = 5'b11000;
    localparam logic [4:0] O_HAZ   = 5'b11010;
    localparam logic [4:0] O_REDIR = 5'b00101;

    pipeline_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .dec_rs         (dec_rs),
        .dec_rt         (dec_rt),
        .dec_uses_rt    (dec_uses_rt),
        .ex_load        (ex_load),
        .ex_wreg        (ex_wreg),
        .branch_judge   (branch_judge),
        .jump_judge     (jump_judge),
        .branch_address (branch_address),
        .jump_address   (jump_address),
        .i_busy         (i_busy),
        .d_busy         (d_busy),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall_count    (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, stall_f, stall_d, flush_d, flush_e, redirect_valid};
    endfunction

    task automatic clear_inputs();
        dec_rs = '0; dec_rt = '0; dec_uses_rt = 1'b0;
        ex_load = 1'b0; ex_wreg = '0;
        branch_judge = 1'b0; jump_judge = 1'b0;
        branch_address = '0; jump_address = '0;
        i_busy = 1'b0; d_busy = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clear_inputs();
        reset = 1'b0;
        d_busy = 1'b1; ex_load = 1'b1; ex_wreg = 5'd5; dec_rs = 5'd5;
        #3;
        check("rst_outs", outs(), O_IDLE);
        check("rst_pc", redirect_pc, 32'd0);
        check("rst_cnt", stall_count, 32'd0);

        @(negedge clk); clear_inputs(); reset = 1'b1; #1;
        check("idle", outs(), O_IDLE);

        // Load-use hazard; simultaneous branch must be ignored
        @(negedge clk);
        ex_load = 1'b1; ex_wreg = 5'd5; dec_rs = 5'd5;
        branch_judge = 1'b1; branch_address = 32'h0000_0BAD; #1;
        check("haz_rs", outs(), O_HAZ);
        @(negedge clk);
        branch_judge = 1'b0; ex_wreg = 5'd0; dec_rs = 5'd0; #1;
        check("haz_r0_no_redir", outs(), O_IDLE);
        @(negedge clk);
        ex_wreg = 5'd7; dec_rs = 5'd3; dec_rt = 5'd7; dec_uses_rt = 1'b0; #1;
        check("haz_rt_unused", outs(), O_IDLE);
        dec_uses_rt = 1'b1; #1;
        check("haz_rt", outs(), O_HAZ);
        ex_load = 1'b0; #1;
        check("no_load", outs(), O_IDLE);
        ex_load = 1'b1; d_busy = 1'b1; #1;
        check("dbusy_over_haz", outs(), O_STALL);
        @(negedge clk); clear_inputs(); #1;
        check("dwait_exit_nopend", outs(), O_IDLE);
        @(negedge clk); #1;
        check("idle2", outs(), O_IDLE);

        // Branch beats jump; redirect next cycle; inputs in REDIR ignored
        @(negedge clk);
        branch_judge = 1'b1; branch_address = 32'h0040_0020;
        jump_judge = 1'b1; jump_address = 32'h0040_0999; #1;
        check("br_cycle", outs(), O_IDLE);
        @(negedge clk);
        branch_address = 32'hDEAD_BEEF; jump_judge = 1'b0; #1;
        check("br_redir", outs(), O_REDIR);
        check("br_pc", redirect_pc, 32'h0040_0020);
        @(negedge clk); branch_judge = 1'b0; #1;
        check("br_done", outs(), O_IDLE);
        check("br_pc0", redirect_pc, 32'd0);

        // Jump with instruction fetch busy for three cycles
        @(negedge clk);
        jump_judge = 1'b1; jump_address = 32'h0040_1000; i_busy = 1'b1; #1;
        check("jmp_cycle", outs(), O_IDLE);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); jump_judge = 1'b0; i_busy = (k < 3); #1;
            check($sformatf("jmp_iwait%0d", k), outs(), O_STALL);
        end
        @(negedge clk); #1;
        check("jmp_redir", outs(), O_REDIR);
        check("jmp_pc", redirect_pc, 32'h0040_1000);
        check("jmp_cnt", stall_count, 32'd5);
        @(negedge clk); #1;
        check("jmp_done", outs(), O_IDLE);

        // Latched target survives a data-memory wait
        @(negedge clk);
        branch_judge = 1'b1; branch_address = 32'h0040_0100; i_busy = 1'b1; #1;
        check("dw_latch", outs(), O_IDLE);
        @(negedge clk); branch_judge = 1'b0; i_busy = 1'b0; d_busy = 1'b1; #1;
        check("dw_stall1", outs(), O_STALL);
        @(negedge clk); #1;
        check("dw_stall2", outs(), O_STALL);
        @(negedge clk); d_busy = 1'b0; branch_address = 32'h1234_5678; #1;
        check("dw_exit", outs(), O_IDLE);
        @(negedge clk); #1;
        check("dw_redir", outs(), O_REDIR);
        check("dw_pc", redirect_pc, 32'h0040_0100);
        @(negedge clk); #1;
        check("dw_done", outs(), O_IDLE);
        check("dw_cnt", stall_count, 32'd7);

        // Reset pulsed during IWAIT discards the target
        @(negedge clk);
        jump_judge = 1'b1; jump_address = 32'h0040_2000; i_busy = 1'b1; #1;
        @(negedge clk); jump_judge = 1'b0; #1;
        check("iw_stall", outs(), O_STALL);
        #1 reset = 1'b0; #1;
        check("rst_mid_outs", outs(), O_IDLE);
        check("rst_mid_cnt", stall_count, 32'd0);
        @(negedge clk);
        reset = 1'b1; i_busy = 1'b0; ex_load = 1'b1; ex_wreg = 5'd9; dec_rs = 5'd9; #1;
        check("post_rst_haz", outs(), O_HAZ);
        @(negedge clk); ex_load = 1'b0; #1;
        check("post_rst_nored1", outs(), O_IDLE);
        @(negedge clk); #1;
        check("post_rst_nored2", outs(), O_IDLE);

        // Stall counter: ten cycles from reset, then saturation
        reset = 1'b0; #1;
        @(negedge clk); clear_inputs(); reset = 1'b1; i_busy = 1'b1;
        repeat (10) @(negedge clk);
        i_busy = 1'b0; #1;
        check("cnt10", stall_count, 32'd10);
        @(negedge clk); force dut.stall_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk); release dut.stall_cnt_q; #1;
        check("sat_forced", stall_count, 32'hFFFF_FFFF);
        i_busy = 1'b1;
        @(negedge clk); #1;
        check("sat_stalling", outs(), O_STALL);
        @(negedge clk); i_busy = 1'b0; #1;
        check("sat_hold", stall_count, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
